move_engine: RTL and testbench

MOVE_ENGINE -- requirements
Module: move_engine

---
 rtl/move_engine.sv | 138 +++++++++++++
 tb/tb_move_engine.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_engine.sv
// Column-drop move engine: validates a move into a column, commits it to the
// occupancy/owner bitmaps, and reports the outcome a fixed three cycles after acceptance.
module move_engine #(
  parameter int ROWS = 6,
  parameter int COLS = 7,
  localparam int CW = ($clog2(COLS) > 1) ? $clog2(COLS) : 1,
  localparam int RW = $clog2(ROWS + 1),
  localparam int NW = $clog2(ROWS * COLS + 1)
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            clear,
  input  logic            move_req,
  input  logic [CW-1:0]   move_col,
  output logic            busy,
  output logic            move_done,
  output logic            move_ok,
  output logic [RW-1:0]   move_row,
  output logic            move_player,
  output logic            cur_player,
  output logic [NW-1:0]   move_count,
  output logic            board_full,
  input  logic [CW-1:0]   rd_col,
  output logic [ROWS-1:0] rd_onoff,
  output logic [ROWS-1:0] rd_player
);

  typedef enum logic [1:0] {IDLE, CHECK, WRITE, DONE} state_t;

  localparam logic [CW:0]   COLS_W = (CW + 1)'(COLS);
  localparam logic [RW-1:0] ROWS_W = RW'(ROWS);
  localparam logic [NW-1:0] CELLS  = NW'(ROWS * COLS);

  state_t state, next_state;

  logic [ROWS-1:0] occ [COLS];
  logic [ROWS-1:0] own [COLS];

  logic [CW-1:0]   lat_col;
  logic            lat_player;
  logic            valid_r;
  logic [RW-1:0]   height_r;

  logic            lat_col_ok;
  logic            rd_col_ok;
  logic [ROWS-1:0] sel_occ;
  logic [RW-1:0]   height;

  assign board_full = (move_count == CELLS);

  // Columns fill contiguously from bit 0, so the popcount is the next free row.
  always_comb begin
    lat_col_ok = ({1'b0, lat_col} < COLS_W);
    rd_col_ok  = ({1'b0, rd_col} < COLS_W);
    sel_occ    = '0;
    if (lat_col_ok) sel_occ = occ[lat_col];
    height = '0;
    for (int i = 0; i < ROWS; i++) height = height + RW'(sel_occ[i]);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (move_req) next_state = CHECK;
      CHECK:   next_state = WRITE;
      WRITE:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (clear) next_state = IDLE;
  end

  always_comb begin
    busy        = (state != IDLE);
    move_done   = (state == DONE);
    move_ok     = move_done && valid_r;
    move_row    = (move_done && valid_r) ? height_r : '0;
    move_player = move_done ? lat_player : 1'b0;
  end

  // Display reads sample the arrays before this edge's write lands.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < COLS; c++) begin
        occ[c] <= '0;
        own[c] <= '0;
      end
      lat_col    <= '0;
      lat_player <= 1'b0;
      valid_r    <= 1'b0;
      height_r   <= '0;
      move_count <= '0;
      cur_player <= 1'b0;
      rd_onoff   <= '0;
      rd_player  <= '0;
    end else begin
      rd_onoff  <= rd_col_ok ? occ[rd_col] : '0;
      rd_player <= rd_col_ok ? own[rd_col] : '0;
      if (clear) begin
        for (int c = 0; c < COLS; c++) begin
          occ[c] <= '0;
          own[c] <= '0;
        end
        move_count <= '0;
        cur_player <= 1'b0;
        valid_r    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (move_req) begin
              lat_col    <= move_col;
              lat_player <= cur_player;
            end
          end
          CHECK: begin
            valid_r  <= lat_col_ok && (height < ROWS_W) && !board_full;
            height_r <= height;
          end
          WRITE: begin
            if (valid_r) begin
              occ[lat_col][height_r] <= 1'b1;
              own[lat_col][height_r] <= lat_player;
              if (move_count != CELLS) move_count <= move_count + NW'(1);
              cur_player <= ~cur_player;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_move_engine.sv
// Directed self-checking bench for move_engine at the default 6x7 board size.
module tb_move_engine;

  localparam int ROWS = 6;
  localparam int COLS = 7;
  localparam int CW   = 3;
  localparam int RW   = 3;
  localparam int NW   = 6;

  logic            clock;
  logic            resetn;
  logic            clear;
  logic            move_req;
  logic [CW-1:0]   move_col;
  logic            busy;
  logic            move_done;
  logic            move_ok;
  logic [RW-1:0]   move_row;
  logic            move_player;
  logic            cur_player;
  logic [NW-1:0]   move_count;
  logic            board_full;
  logic [CW-1:0]   rd_col;
  logic [ROWS-1:0] rd_onoff;
  logic [ROWS-1:0] rd_player;

  int checks   = 0;
  int failures = 0;

  move_engine #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clock(clock), .resetn(resetn), .clear(clear),
    .move_req(move_req), .move_col(move_col),
    .busy(busy), .move_done(move_done), .move_ok(move_ok),
    .move_row(move_row), .move_player(move_player),
    .cur_player(cur_player), .move_count(move_count), .board_full(board_full),
    .rd_col(rd_col), .rd_onoff(rd_onoff), .rd_player(rd_player)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issues one request from a negedge and returns at the negedge of the done cycle.
  task automatic issue_move(input int col, output logic ok, output logic [RW-1:0] row,
                            output logic pl, output int lat);
    move_req = 1'b1;
    move_col = col[CW-1:0];
    @(negedge clock);
    move_req = 1'b0;
    lat = -1; ok = 1'b0; row = '0; pl = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (move_done) begin
        lat = k; ok = move_ok; row = move_row; pl = move_player;
        break;
      end
      if (k < 6) @(negedge clock);
    end
  endtask

  task automatic read_col(input int col, output logic [ROWS-1:0] on, output logic [ROWS-1:0] pl);
    rd_col = col[CW-1:0];
    @(negedge clock);
    on = rd_onoff;
    pl = rd_player;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; clear = 1'b0; move_req = 1'b0; move_col = '0; rd_col = '0;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (move_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", move_done); end
    checks++; if (move_count !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", move_count); end
    checks++; if (cur_player !== 1'b0) begin failures++; $display("FAIL reset_player got=%0b exp=0", cur_player); end
    checks++; if (board_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", board_full); end
    checks++; if (rd_onoff !== 6'b0) begin failures++; $display("FAIL reset_rd got=%b exp=000000", rd_onoff); end
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single_move();
    logic ok, pl;
    logic [RW-1:0] row;
    logic [ROWS-1:0] on, own;
    int lat;
    rd_col = 3'd3;
    issue_move(3, ok, row, pl, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL single_latency got=%0d exp=3", lat); end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_ok got=%0b exp=1", ok); end
    checks++; if (row !== 3'd0) begin failures++; $display("FAIL single_row got=%0d exp=0", row); end
    checks++; if (pl !== 1'b0) begin failures++; $display("FAIL single_player got=%0b exp=0", pl); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_done got=%0b exp=1", busy); end
    checks++; if (rd_onoff !== 6'b000000) begin failures++; $display("FAIL single_rd_prewrite got=%b exp=000000", rd_onoff); end
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_idle got=%0b exp=0", busy); end
    checks++; if (cur_player !== 1'b1) begin failures++; $display("FAIL single_cur got=%0b exp=1", cur_player); end
    checks++; if (move_count !== 6'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", move_count); end
    read_col(3, on, own);
    checks++; if (on !== 6'b000001) begin failures++; $display("FAIL single_onoff got=%b exp=000001", on); end
    checks++; if (own !== 6'b000000) begin failures++; $display("FAIL single_owner got=%b exp=000000", own); end
  endtask

  task automatic test_column_fill();
    logic ok, pl;
    logic [RW-1:0] row;
    logic [ROWS-1:0] on, own;
    int lat;
    do_clear();
    for (int i = 0; i < 6; i++) begin
      issue_move(0, ok, row, pl, lat);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL fill_ok[%0d] got=%0b exp=1", i, ok); end
      checks++; if (row !== RW'(i)) begin failures++; $display("FAIL fill_row[%0d] got=%0d exp=%0d", i, row, i); end
      checks++; if (pl !== 1'(i % 2)) begin failures++; $display("FAIL fill_player[%0d] got=%0b exp=%0d", i, pl, i % 2); end
      @(negedge clock);
    end
    issue_move(0, ok, row, pl, lat);
    checks++; if (ok !== 1'b0) begin failures++; $display("FAIL full_col_ok got=%0b exp=0", ok); end
    checks++; if (row !== 3'd0) begin failures++; $display("FAIL full_col_row got=%0d exp=0", row); end
    @(negedge clock);
    checks++; if (move_count !== 6'd6) begin failures++; $display("FAIL full_col_count got=%0d exp=6", move_count); end
    checks++; if (cur_player !== 1'b0) begin failures++; $display("FAIL full_col_cur got=%0b exp=0", cur_player); end
    read_col(0, on, own);
    checks++; if (on !== 6'b111111) begin failures++; $display("FAIL col0_onoff got=%b exp=111111", on); end
    checks++; if (own !== 6'b101010) begin failures++; $display("FAIL col0_owner got=%b exp=101010", own); end
  endtask

  task automatic test_bad_col();
    logic ok, pl;
    logic [RW-1:0] row;
    logic [ROWS-1:0] on, own;
    int lat;
    do_clear();
    issue_move(7, ok, row, pl, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL badcol_latency got=%0d exp=3", lat); end
    checks++; if (ok !== 1'b0) begin failures++; $display("FAIL badcol_ok got=%0b exp=0", ok); end
    @(negedge clock);
    checks++; if (move_count !== 6'd0) begin failures++; $display("FAIL badcol_count got=%0d exp=0", move_count); end
    checks++; if (cur_player !== 1'b0) begin failures++; $display("FAIL badcol_cur got=%0b exp=0", cur_player); end
    read_col(7, on, own);
    checks++; if (on !== 6'b0) begin failures++; $display("FAIL badcol_rd got=%b exp=000000", on); end
  endtask

  task automatic test_back_to_back();
    int dones;
    int first;
    int last;
    do_clear();
    dones = 0; first = -1; last = -1;
    move_req = 1'b1;
    move_col = 3'd1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      if (move_done) begin
        dones++;
        if (first < 0) first = k;
        last = k;
      end
    end
    move_req = 1'b0;
    repeat (4) @(negedge clock);
    checks++; if (dones !== 4) begin failures++; $display("FAIL b2b_dones got=%0d exp=4", dones); end
    checks++; if (first !== 3) begin failures++; $display("FAIL b2b_first got=%0d exp=3", first); end
    checks++; if (last !== 15) begin failures++; $display("FAIL b2b_last got=%0d exp=15", last); end
    checks++; if (move_count !== 6'd4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", move_count); end
  endtask

  task automatic test_busy_ignore();
    int dones;
    logic [ROWS-1:0] on, own;
    do_clear();
    move_req = 1'b1;
    move_col = 3'd2;
    @(negedge clock);
    move_col = 3'd5;
    @(negedge clock);
    @(negedge clock);
    move_req = 1'b0;
    checks++; if (move_done !== 1'b1) begin failures++; $display("FAIL ignore_done got=%0b exp=1", move_done); end
    dones = 0;
    repeat (6) begin
      @(negedge clock);
      if (move_done) dones++;
    end
    checks++; if (dones !== 0) begin failures++; $display("FAIL ignore_extra_done got=%0d exp=0", dones); end
    read_col(2, on, own);
    checks++; if (on !== 6'b000001) begin failures++; $display("FAIL ignore_col2 got=%b exp=000001", on); end
    read_col(5, on, own);
    checks++; if (on !== 6'b000000) begin failures++; $display("FAIL ignore_col5 got=%b exp=000000", on); end
  endtask

  task automatic test_board_full();
    logic ok, pl;
    logic [RW-1:0] row;
    logic [ROWS-1:0] on, own;
    int lat;
    do_clear();
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        issue_move(c, ok, row, pl, lat);
        checks++; if (ok !== 1'b1 || row !== RW'(r)) begin
          failures++; $display("FAIL board_move[%0d,%0d] got ok=%0b row=%0d exp ok=1 row=%0d", c, r, ok, row, r);
        end
        @(negedge clock);
      end
    end
    checks++; if (move_count !== 6'd42) begin failures++; $display("FAIL board_count got=%0d exp=42", move_count); end
    checks++; if (board_full !== 1'b1) begin failures++; $display("FAIL board_full got=%0b exp=1", board_full); end
    issue_move(3, ok, row, pl, lat);
    checks++; if (ok !== 1'b0) begin failures++; $display("FAIL board_extra_ok got=%0b exp=0", ok); end
    @(negedge clock);
    checks++; if (move_count !== 6'd42) begin failures++; $display("FAIL board_sat got=%0d exp=42", move_count); end
    issue_move(4, ok, row, pl, lat);
    @(negedge clock);
    checks++; if (cur_player !== 1'b0) begin failures++; $display("FAIL board_cur_held got=%0b exp=0", cur_player); end
    do_clear();
    checks++; if (move_count !== 6'd0) begin failures++; $display("FAIL clear_count got=%0d exp=0", move_count); end
    checks++; if (board_full !== 1'b0) begin failures++; $display("FAIL clear_full got=%0b exp=0", board_full); end
    for (int c = 0; c < COLS; c++) begin
      read_col(c, on, own);
      checks++; if (on !== 6'b0 || own !== 6'b0) begin
        failures++; $display("FAIL clear_col[%0d] got on=%b own=%b exp 000000", c, on, own);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int dones;
    logic [ROWS-1:0] on, own;
    do_clear();
    rd_col = 3'd4;
    move_req = 1'b1;
    move_col = 3'd4;
    @(negedge clock);
    move_req = 1'b0;
    @(negedge clock);
    resetn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%0b exp=0", busy); end
    checks++; if (move_done !== 1'b0) begin failures++; $display("FAIL rst_mid_done got=%0b exp=0", move_done); end
    checks++; if (move_count !== 6'd0) begin failures++; $display("FAIL rst_mid_count got=%0d exp=0", move_count); end
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    read_col(4, on, own);
    checks++; if (on !== 6'b0) begin failures++; $display("FAIL rst_mid_col4 got=%b exp=000000", on); end
    clear = 1'b1;
    move_req = 1'b1;
    move_col = 3'd2;
    @(negedge clock);
    clear = 1'b0;
    move_req = 1'b0;
    dones = 0;
    repeat (6) begin
      if (move_done || busy) dones++;
      @(negedge clock);
    end
    checks++; if (dones !== 0) begin failures++; $display("FAIL clear_vs_req got=%0d exp=0", dones); end
    checks++; if (move_count !== 6'd0) begin failures++; $display("FAIL clear_vs_req_count got=%0d exp=0", move_count); end
  endtask

  initial begin
    test_reset();
    test_single_move();
    test_column_fill();
    test_bad_col();
    test_back_to_back();
    test_busy_ignore();
    test_board_full();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
